// File: rtl/ofd5_sched.sv
// Round-robin scheduler sharing the 5-bit ofd5 output register bank between sources A and B.
// Each accepted word is held HOLD cycles on DOUT, then IDLE_VAL is driven for GAP cycles.
//
// state | meaning
// IDLE  | no word active; every edge is a load opportunity
// HOLD  | accepted word on DOUT; counter holds remaining hold cycles
// GAP   | IDLE_VAL on DOUT; counter holds remaining gap cycles
module ofd5_sched #(
    parameter int unsigned HOLD     = 3,
    parameter int unsigned GAP      = 1,
    parameter logic [4:0]  IDLE_VAL = 5'b00000
) (
    input  logic       CK,
    input  logic       RSTN,
    input  logic       EN,
    input  logic       REQA,
    input  logic [4:0] DA,
    output logic       ACKA,
    input  logic       REQB,
    input  logic [4:0] DB,
    output logic       ACKB,
    output logic [4:0] DOUT,
    output logic       VALID,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LD  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
    localparam logic       GAP_ZERO = (GAP == 0);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       acka_q, acka_d;
    logic       ackb_q, ackb_d;
    logic       busy_q, busy_d;
    logic       last_b_q, last_b_d;

    logic       load_opp;
    logic       do_load;
    logic       win_b;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            dout_q   <= IDLE_VAL;
            valid_q  <= 1'b0;
            acka_q   <= 1'b0;
            ackb_q   <= 1'b0;
            busy_q   <= 1'b0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            acka_q   <= acka_d;
            ackb_q   <= ackb_d;
            busy_q   <= busy_d;
            last_b_q <= last_b_d;
        end
    end

    // With GAP=0 the last HOLD cycle doubles as the load opportunity, giving back-to-back words.
    always_comb begin
        load_opp = 1'b0;
        case (state_q)
            ST_IDLE: load_opp = 1'b1;
            ST_HOLD: load_opp = (cnt_q == 8'd0) && GAP_ZERO;
            ST_GAP:  load_opp = (cnt_q == 8'd0);
            default: load_opp = 1'b0;
        endcase
        do_load = load_opp && EN && (REQA || REQB);
        win_b   = REQB && (!REQA || !last_b_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        acka_d   = 1'b0;
        ackb_d   = 1'b0;
        last_b_d = last_b_q;

        if (do_load) begin
            state_d  = ST_HOLD;
            cnt_d    = HOLD_LD;
            dout_d   = win_b ? DB : DA;
            valid_d  = 1'b1;
            acka_d   = !win_b;
            ackb_d   = win_b;
            last_b_d = win_b;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_HOLD: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (!GAP_ZERO) begin
                        dout_d  = IDLE_VAL;
                        valid_d = 1'b0;
                        cnt_d   = GAP_LD;
                        state_d = ST_GAP;
                    end else begin
                        dout_d  = IDLE_VAL;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    dout_d  = IDLE_VAL;
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign ACKA  = acka_q;
    assign ACKB  = ackb_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_ofd5_sched.sv
// Scoreboard bench for ofd5_sched: two instances (GAP=1 and GAP=0) share stimulus and are
// compared every cycle against a timeline model of word slots.
module tb_ofd5_sched;

    localparam int         HOLD     = 3;
    localparam int         GAP0     = 1;
    localparam int         GAP1     = 0;
    localparam logic [4:0] IDLE_VAL = 5'b00000;

    typedef struct packed {
        logic [4:0] dout;
        logic       valid;
        logic       acka;
        logic       ackb;
        logic       busy;
    } exp_t;

    logic       CK = 1'b0;
    logic       RSTN, EN, REQA, REQB;
    logic [4:0] DA, DB;
    logic [4:0] dout0, dout1;
    logic       valid0, valid1, acka0, acka1, ackb0, ackb1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    ofd5_sched #(.HOLD(HOLD), .GAP(GAP0), .IDLE_VAL(IDLE_VAL)) u_dut0 (
        .CK(CK), .RSTN(RSTN), .EN(EN),
        .REQA(REQA), .DA(DA), .ACKA(acka0),
        .REQB(REQB), .DB(DB), .ACKB(ackb0),
        .DOUT(dout0), .VALID(valid0), .BUSY(busy0)
    );

    ofd5_sched #(.HOLD(HOLD), .GAP(GAP1), .IDLE_VAL(IDLE_VAL)) u_dut1 (
        .CK(CK), .RSTN(RSTN), .EN(EN),
        .REQA(REQA), .DA(DA), .ACKA(acka1),
        .REQB(REQB), .DB(DB), .ACKB(ackb1),
        .DOUT(dout1), .VALID(valid1), .BUSY(busy1)
    );

    initial forever #5 CK = ~CK;

    // Model: a word loaded at edge t owns DOUT for edges t..t+HOLD-1 and the port
    // is free again from edge t+HOLD+GAP onward.
    longint     edge_n = 0;
    bit         have_w [2];
    longint     t_ld   [2];
    logic [4:0] word_m [2];
    bit         last_b_m [2];
    exp_t       q0[$];
    exp_t       q1[$];

    task automatic model_step(input int i, input int gap, output exp_t e);
        bit     free;
        bit     win_b;
        longint age;
        e.acka = 1'b0;
        e.ackb = 1'b0;
        if (!RSTN) begin
            have_w[i]   = 1'b0;
            last_b_m[i] = 1'b1;
        end else begin
            free = !have_w[i] || ((edge_n - t_ld[i]) >= longint'(HOLD + gap));
            if (free && EN && (REQA || REQB)) begin
                if (REQA && REQB) win_b = !last_b_m[i];
                else              win_b = REQB;
                have_w[i]   = 1'b1;
                t_ld[i]     = edge_n;
                word_m[i]   = win_b ? DB : DA;
                last_b_m[i] = win_b;
                e.acka      = !win_b;
                e.ackb      = win_b;
            end
        end
        age     = edge_n - t_ld[i];
        e.valid = have_w[i] && (age < longint'(HOLD));
        e.dout  = e.valid ? word_m[i] : IDLE_VAL;
        e.busy  = have_w[i] && (age < longint'(HOLD + gap));
    endtask

    initial begin
        exp_t e0, e1;
        have_w   = '{1'b0, 1'b0};
        last_b_m = '{1'b1, 1'b1};
        forever begin
            @(posedge CK);
            edge_n++;
            model_step(0, GAP0, e0);
            q0.push_back(e0);
            model_step(1, GAP1, e1);
            q1.push_back(e1);
        end
    end

    task automatic check_out(input string name, input exp_t exp, input exp_t act);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got dout=%h valid=%b acka=%b ackb=%b busy=%b, expected dout=%h valid=%b acka=%b ackb=%b busy=%b",
                     name, $time, act.dout, act.valid, act.acka, act.ackb, act.busy,
                     exp.dout, exp.valid, exp.acka, exp.ackb, exp.busy);
        end
    endtask

    initial begin
        exp_t ex;
        forever begin
            @(negedge CK);
            if (q0.size() > 0) begin
                ex = q0.pop_front();
                check_out("gap1_cycle", ex, {dout0, valid0, acka0, ackb0, busy0});
            end
            if (q1.size() > 0) begin
                ex = q1.pop_front();
                check_out("gap0_cycle", ex, {dout1, valid1, acka1, ackb1, busy1});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CK);
    endtask

    task automatic wait_ack(input int which, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CK);
            case (which)
                0:       seen = acka0;
                1:       seen = ackb0;
                2:       seen = ackb1;
                default: seen = acka0 | ackb0;
            endcase
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no ack within 20 cycles, got 0, required 1", name);
        end
    endtask

    initial begin
        exp_t rst_exp;
        rst_exp = {IDLE_VAL, 1'b0, 1'b0, 1'b0, 1'b0};
        RSTN = 1'b0; EN = 1'b1;
        REQA = 1'b0; REQB = 1'b0; DA = 5'h00; DB = 5'h00;
        idle(3);
        RSTN = 1'b1;
        idle(2);

        // contention straight out of reset: A first, then alternate
        REQA = 1'b1; DA = 5'h0A; REQB = 1'b1; DB = 5'h11;
        idle(17);
        REQA = 1'b0; REQB = 1'b0;
        idle(8);

        // single A word
        REQA = 1'b1; DA = 5'h15;
        wait_ack(0, "single_a_ack");
        REQA = 1'b0;
        idle(8);

        // B-only stream, paced by the GAP=0 instance
        REQB = 1'b1; DB = 5'h01;
        wait_ack(2, "b_stream_ack1");
        DB = 5'h02;
        wait_ack(2, "b_stream_ack2");
        DB = 5'h03;
        wait_ack(2, "b_stream_ack3");
        REQB = 1'b0;
        idle(8);

        // EN dropped mid-word with B pending
        REQA = 1'b1; DA = 5'h0A;
        wait_ack(0, "en_a_ack");
        REQA = 1'b0;
        @(negedge CK);
        EN = 1'b0; REQB = 1'b1; DB = 5'h1B;
        idle(8);
        EN = 1'b1;
        wait_ack(1, "en_b_ack");
        REQB = 1'b0;
        idle(6);

        // async reset during HOLD
        REQA = 1'b1; DA = 5'h1F;
        wait_ack(0, "rst_a_ack");
        #2 RSTN = 1'b0;
        #1;
        check_out("async_rst_gap1", rst_exp, {dout0, valid0, acka0, ackb0, busy0});
        check_out("async_rst_gap0", rst_exp, {dout1, valid1, acka1, ackb1, busy1});
        @(negedge CK);
        REQA = 1'b1; DA = 5'h03; REQB = 1'b1; DB = 5'h1C;
        RSTN = 1'b1;
        wait_ack(3, "post_rst_ack");
        n_checks++;
        if (!(acka0 === 1'b1 && ackb0 === 1'b0 && acka1 === 1'b1)) begin
            n_fail++;
            $display("FAIL post_rst_first_grant: got acka0=%b ackb0=%b acka1=%b, required 1 0 1",
                     acka0, ackb0, acka1);
        end
        idle(6);
        REQA = 1'b0; REQB = 1'b0;
        idle(8);

        // REQA pulsed during HOLD and withdrawn
        REQB = 1'b1; DB = 5'h07;
        wait_ack(1, "pulse_b_ack");
        REQB = 1'b0;
        @(negedge CK);
        REQA = 1'b1; DA = 5'h09;
        @(negedge CK);
        REQA = 1'b0;
        idle(8);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge CK);
            if (!RSTN) begin
                RSTN = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                #2 RSTN = 1'b0;
            end else begin
                EN = ($urandom_range(0, 9) != 0);
                if (REQA && acka0) begin
                    if ($urandom_range(0, 1) == 1) DA = 5'($urandom_range(0, 31));
                    else REQA = 1'b0;
                end else if (!REQA) begin
                    if ($urandom_range(0, 3) == 0) begin
                        REQA = 1'b1;
                        DA = 5'($urandom_range(0, 31));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    REQA = 1'b0;
                end
                if (REQB && ackb0) begin
                    if ($urandom_range(0, 1) == 1) DB = 5'($urandom_range(0, 31));
                    else REQB = 1'b0;
                end else if (!REQB) begin
                    if ($urandom_range(0, 3) == 0) begin
                        REQB = 1'b1;
                        DB = 5'($urandom_range(0, 31));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    REQB = 1'b0;
                end
            end
        end
        RSTN = 1'b1;
        REQA = 1'b0; REQB = 1'b0; EN = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofd5_sched.md
Name: ofd5_sched

Overview:
- Two-requester output scheduler that shares the 5-bit registered output port (the ofd5 IOB flip-flop bank) between two internal sources, A and B.
- DOUT[4:0] connects directly to D0..D4 of the ofd5 bank. The ofd5 bank adds one more CK cycle before the value reaches the pads.
- Each accepted word is held on DOUT for HOLD cycles, followed by GAP cycles of IDLE_VAL.
- When both sources request, they are granted alternately (round-robin).

Parameters:
- HOLD, 3, cycles each accepted word stays on DOUT (legal range 1..255)
- GAP, 1, cycles of IDLE_VAL between words (legal range 0..255)
- IDLE_VAL, 5'b00000, value driven on DOUT when no word is active

Ports:
- CK  input  1  clock, all logic rising-edge
- RSTN  input  1  asynchronous active-low reset
- EN  input  1  when low, no new word is loaded; an active word completes normally
- REQA  input  1  source A request; held high with DA stable until ACKA
- DA  input  5  source A word
- ACKA  output  1  one-cycle pulse: DA captured into DOUT
- REQB  input  1  source B request; held high with DB stable until ACKB
- DB  input  5  source B word
- ACKB  output  1  one-cycle pulse: DB captured into DOUT
- DOUT  output  5  word to the ofd5 D0..D4 inputs
- VALID  output  1  high while DOUT carries an accepted word
- BUSY  output  1  high while the state is not IDLE

Behaviour:
- All outputs are registered.
- Reset (RSTN low) takes effect immediately, including mid-word. Reset values:
  - DOUT=IDLE_VAL
  - VALID=0, ACKA=0, ACKB=0, BUSY=0
  - state=IDLE, hold/gap counter=0
  - round-robin pointer LAST=B, so A wins the first contention.
- Internal counter is 8-bit.
- States: IDLE, HOLD, GAP.
- A load opportunity is a rising edge where any of the following holds:
  - state=IDLE
  - state=HOLD, counter=0 and GAP=0
  - state=GAP and counter=0
- Load at a load opportunity with EN=1 and REQA or REQB high:
  - Winner selection:
    - only one source requesting: that source wins
    - both requesting: the source opposite LAST wins
  - DOUT<=winner data, VALID<=1, winner ACK<=1 (one cycle), LAST<=winner.
  - counter<=HOLD-1, state<=HOLD.
- Latency: REQ sampled high at edge t (IDLE) gives DOUT, VALID and ACK updated after edge t. The value appears at the pads after edge t+1.
- HOLD with counter>0: counter decrements; DOUT held.
- HOLD with counter=0:
  - If GAP>0: DOUT<=IDLE_VAL, VALID<=0, counter<=GAP-1, state<=GAP.
  - If GAP=0: a load if one qualifies, otherwise DOUT<=IDLE_VAL, VALID<=0, state<=IDLE.
- GAP with counter>0: counter decrements.
- GAP with counter=0: a load if one qualifies, otherwise state<=IDLE.
- Word timing: each word occupies exactly HOLD cycles. Minimum word-to-word period is HOLD+GAP cycles.
- ACKA/ACKB are never high in the same cycle. They are low on every edge that is not a load.
- REQ seen in the ACK cycle: the arbiter is in HOLD and ignores it. The requester drops REQ or presents the next word with REQ still high; that word is taken at the next load opportunity.
- REQ withdrawn before ACK: no grant, no state change.
- EN low: no loads. An active HOLD/GAP runs to completion, then state goes to IDLE. Loading resumes at the first opportunity after EN returns high.
- BUSY = (state != IDLE).

Test Plan:
- Default params, single request REQA=1, DA=5'h15 at IDLE:
  - ACKA pulses one cycle; DOUT=15 and VALID=1 for 3 cycles.
  - Then DOUT=00 and VALID=0 for 1 cycle.
  - BUSY falls 4 cycles after the load; ACKB stays 0.
- REQA and REQB held high, DA=5'h0A, DB=5'h11 (default params):
  - Grants go A,B,A,B with one grant every 4 cycles.
  - DOUT sequence: 0A,0A,0A,00,11,11,11,00,...
- GAP=0, HOLD=3, B only, words 01,02,03 each presented after the previous ACKB:
  - DOUT is 01×3, 02×3, 03×3 back-to-back; VALID high 9 consecutive cycles.
  - Then DOUT=IDLE_VAL.
- EN dropped during the 2nd HOLD cycle of word 0A with REQB high:
  - 0A completes (3 cycles) and the gap follows; no ACKB while EN=0.
  - EN raised: ACKB on the first edge where state=IDLE and EN=1.
- RSTN pulsed low during HOLD of word 1F:
  - DOUT goes to 00 and VALID/BUSY go to 0 asynchronously.
  - After release with both REQs high, A is granted first.
- REQA pulsed one cycle during HOLD and withdrawn before the load opportunity:
  - No ACKA; state goes to IDLE after the current word and gap.
